// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and memory-wait stalls,
// branch flushes, wait timeout. Optional performance counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        mem_ready,
  output logic        EnF,
  output logic        EnD,
  output logic        EnE,
  output logic        EnM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       wait_stall_s;
  logic       lw_stall_s;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign wait_stall_s = MemReqM & ~mem_ready;
  assign lw_stall_s   = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

  // Forwarding selects, forced to regfile while reset is held.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset_n) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end else begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  // Stage enables and flushes; a memory wait freezes everything, including a
  // pending branch, which then flushes naturally once the wait releases.
  always_comb begin
    EnF    = 1'b1;
    EnD    = 1'b1;
    EnE    = 1'b1;
    EnM    = 1'b1;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!reset_n) begin
      EnF = 1'b1;
    end else if (wait_stall_s) begin
      EnF = 1'b0;
      EnD = 1'b0;
      EnE = 1'b0;
      EnM = 1'b0;
    end else begin
      if (lw_stall_s) begin
        EnF    = 1'b0;
        EnD    = 1'b0;
        FlushE = 1'b1;
      end else begin
        FlushE = 1'b0;
      end
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else begin
        FlushD = 1'b0;
      end
    end
  end

  // Wait FSM next state, saturating wait counter and sticky timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = 8'd0;
        if (wait_stall_s) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          state_d = MEM_WAIT;
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
          if (wait_cnt_d >= MAX_WAIT_C) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Wait FSM state, counter and timeout flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Counter increments; both wrap modulo 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, ~EnF};
    flush_count_d  = flush_count_q + {31'd0, (FlushD | FlushE)};
  end

  // Performance counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes reference-model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;
  localparam int MW = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, mem_ready;
  logic        EnF, EnD, EnE, EnM, FlushD, FlushE, mem_timeout;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cycles, flush_count;

  hazard_ctrl #(.MAX_WAIT(MW)) dut (
    .clock(clock), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .mem_ready(mem_ready),
    .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rse;
    logic       pcsrc;
    logic [4:0] rdm, rdw;
    logic       rwm, rww, memreq, ready;
  } stim_t;

  typedef struct {
    logic        en_f, en_d, en_e, en_m, fl_d, fl_e, to;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: are we waiting on memory, for how long, and the
  // sticky timeout plus the two activity counters.
  bit          m_waiting = 1'b0;
  int          m_waited  = 0;
  bit          m_to      = 1'b0;
  logic [31:0] m_sc      = 32'd0;
  logic [31:0] m_fc      = 32'd0;

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [4:0] rs);
    if (s.rwm && s.rdm != 5'd0 && s.rdm == rs) return 2'b10;
    if (s.rww && s.rdw != 5'd0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input stim_t s, input logic rst_v);
    exp_t e;
    bit   stall_mem, load_use;
    @(posedge clock);
    #1;
    reset_n = rst_v;
    Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e; RdE = s.rde;
    ResultSrcE = s.rse; PCSrcE = s.pcsrc; RdM = s.rdm; RdW = s.rdw;
    RegWriteM = s.rwm; RegWriteW = s.rww; MemReqM = s.memreq; mem_ready = s.ready;
    e.en_f = 1'b1; e.en_d = 1'b1; e.en_e = 1'b1; e.en_m = 1'b1;
    e.fl_d = 1'b0; e.fl_e = 1'b0; e.fa = 2'b00; e.fb = 2'b00;
    if (!rst_v) begin
      m_waiting = 1'b0; m_waited = 0; m_to = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
      e.to = 1'b0; e.sc = 32'd0; e.fc = 32'd0;
    end else begin
      stall_mem = s.memreq && !s.ready;
      load_use  = s.rse == 2'b01 && s.rde != 5'd0 && (s.rde == s.rs1d || s.rde == s.rs2d);
      e.fa = ref_fwd(s, s.rs1e);
      e.fb = ref_fwd(s, s.rs2e);
      if (stall_mem) begin
        e.en_f = 1'b0; e.en_d = 1'b0; e.en_e = 1'b0; e.en_m = 1'b0;
      end else begin
        if (load_use) begin e.en_f = 1'b0; e.en_d = 1'b0; e.fl_e = 1'b1; end
        if (s.pcsrc) begin e.fl_d = 1'b1; e.fl_e = 1'b1; end
      end
      e.to = m_to;
`ifdef HAZARD_PERF_CNT_EN
      e.sc = m_sc; e.fc = m_fc;
`else
      e.sc = 32'd0; e.fc = 32'd0;
`endif
      if (!e.en_f) m_sc = m_sc + 32'd1;
      if (e.fl_d || e.fl_e) m_fc = m_fc + 32'd1;
      if (!m_waiting) begin
        if (stall_mem) m_waiting = 1'b1;
      end else if (s.ready) begin
        m_waiting = 1'b0; m_waited = 0;
      end else begin
        if (m_waited < 255) m_waited = m_waited + 1;
        if (m_waited >= MW) m_to = 1'b1;
      end
    end
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp_v);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      chk("EnF", {31'd0, EnF}, {31'd0, e.en_f});
      chk("EnD", {31'd0, EnD}, {31'd0, e.en_d});
      chk("EnE", {31'd0, EnE}, {31'd0, e.en_e});
      chk("EnM", {31'd0, EnM}, {31'd0, e.en_m});
      chk("FlushD", {31'd0, FlushD}, {31'd0, e.fl_d});
      chk("FlushE", {31'd0, FlushE}, {31'd0, e.fl_e});
      chk("ForwardAE", {30'd0, ForwardAE}, {30'd0, e.fa});
      chk("ForwardBE", {30'd0, ForwardBE}, {30'd0, e.fb});
      chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.to});
      chk("stall_cycles", stall_cycles, e.sc);
      chk("flush_count", flush_count, e.fc);
    end
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;
    reset_n = 1'b0;
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReqM = 1'b0; mem_ready = 1'b0;

    // Reset with hazard-looking inputs, which must not leak through.
    s = idle; s.rs1e = 5'd5; s.rdm = 5'd5; s.rwm = 1'b1; s.memreq = 1'b1; s.pcsrc = 1'b1;
    drive(s, 1'b0);
    drive(idle, 1'b0);
    drive(idle, 1'b1);

    // Forwarding priority: Memory over Writeback, then rd==0 falls back.
    s = idle; s.rs1e = 5'd5; s.rdm = 5'd5; s.rwm = 1'b1; s.rdw = 5'd5; s.rww = 1'b1;
    drive(s, 1'b1);
    s.rdm = 5'd0; drive(s, 1'b1);
    s.rs2e = 5'd5; s.rww = 1'b0; drive(s, 1'b1);

    // Load-use stall for one cycle, then rd==0 gives no stall.
    s = idle; s.rse = 2'b01; s.rde = 5'd7; s.rs2d = 5'd7;
    drive(s, 1'b1);
    drive(idle, 1'b1);
    s.rde = 5'd0; drive(s, 1'b1);

    // Branch alone, then branch coinciding with load-use.
    s = idle; s.pcsrc = 1'b1; drive(s, 1'b1);
    s.rse = 2'b01; s.rde = 5'd3; s.rs1d = 5'd3; drive(s, 1'b1);

    // Three-cycle memory wait, no timeout.
    s = idle; s.memreq = 1'b1;
    repeat (3) drive(s, 1'b1);
    s.ready = 1'b1; drive(s, 1'b1);
    drive(idle, 1'b1);

    // Branch held during wait flushes only when the wait releases.
    s = idle; s.memreq = 1'b1; s.pcsrc = 1'b1; s.rse = 2'b01; s.rde = 5'd4; s.rs1d = 5'd4;
    repeat (2) drive(s, 1'b1);
    s.ready = 1'b1; drive(s, 1'b1);
    drive(idle, 1'b1);

    // Timeout: set after MW wait cycles, sticky until reset.
    s = idle; s.memreq = 1'b1;
    repeat (MW + 3) drive(s, 1'b1);
    s.ready = 1'b1; drive(s, 1'b1);
    repeat (3) drive(idle, 1'b1);
    drive(idle, 1'b0);
    drive(idle, 1'b1);

    // Reset asserted in the middle of a wait.
    s = idle; s.memreq = 1'b1;
    repeat (MW - 1) drive(s, 1'b1);
    drive(s, 1'b0);
    s.ready = 1'b1; drive(s, 1'b1);
    drive(idle, 1'b1);

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      s.rs1d   = 5'($urandom_range(0, 3));
      s.rs2d   = 5'($urandom_range(0, 3));
      s.rs1e   = 5'($urandom_range(0, 3));
      s.rs2e   = 5'($urandom_range(0, 3));
      s.rde    = 5'($urandom_range(0, 3));
      s.rdm    = 5'($urandom_range(0, 3));
      s.rdw    = 5'($urandom_range(0, 3));
      s.rse    = 2'($urandom_range(0, 3));
      s.pcsrc  = ($urandom_range(0, 4) == 0);
      s.rwm    = 1'($urandom_range(0, 1));
      s.rww    = 1'($urandom_range(0, 1));
      s.memreq = ($urandom_range(0, 2) == 0);
      s.ready  = ($urandom_range(0, 9) < 6);
      drive(s, ($urandom_range(0, 199) != 0));
    end

    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
